// File: rtl/fifo_pkg.sv
// Shared types for the FIFO read-side stream adapter.
// Holds the output-buffer occupancy encoding and the default word width.
package fifo_pkg;

  localparam int FIFO_WIDTH = 16;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  function automatic logic [2:0] occ_cnt(occ_e o);
    logic [2:0] n;
    n = 3'd0;
    unique case (o)
      OCC_EMPTY: n = 3'd0;
      OCC_ONE:   n = 3'd1;
      OCC_TWO:   n = 3'd2;
      default:   n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/fifo_reader.sv
// Turns a sync FIFO's read/data-next-cycle port into a valid/ready stream.
// Optional word_count delivered-word counter under FIFO_READER_STATS_EN.
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_read,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef FIFO_READER_STATS_EN
  output logic [15:0]      word_count,
`endif
  output logic [WIDTH-1:0] out_data
);

  occ_e             occ_q, occ_d;
  logic             inflight_q, inflight_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;

  logic       pop;
  logic       cap;
  logic       issue;
  logic [2:0] level;

  assign out_valid = (occ_q != OCC_EMPTY);
  assign out_data  = head_q;
  assign pop       = out_valid & out_ready;
  // A word landing during clear belongs to the flushed stream.
  assign cap       = inflight_q & ~clear;

  // pop implies occupancy >= 1, so this never underflows
  assign level = occ_cnt(occ_q) + {2'b0, inflight_q} - {2'b0, pop};
  assign issue = ~fifo_empty & ~clear & (level < 3'd2);

  assign fifo_read  = issue & reset_n;
  assign inflight_d = issue;

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    if (clear) begin
      occ_d = OCC_EMPTY;
    end else begin
      unique case (occ_q)
        OCC_EMPTY: begin
          if (cap) begin
            head_d = fifo_data;
            occ_d  = OCC_ONE;
          end
        end
        OCC_ONE: begin
          unique case ({cap, pop})
            2'b11: head_d = fifo_data;
            2'b10: begin
              tail_d = fifo_data;
              occ_d  = OCC_TWO;
            end
            2'b01: occ_d = OCC_EMPTY;
            default: ;
          endcase
        end
        OCC_TWO: begin
          if (pop) begin
            head_d = tail_q;
            if (cap) tail_d = fifo_data;
            else     occ_d  = OCC_ONE;
          end
        end
        default: occ_d = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      occ_q      <= OCC_EMPTY;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

`ifdef FIFO_READER_STATS_EN
  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q + {15'd0, pop};
    if (clear) count_d = 16'd0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) count_q <= 16'd0;
    else          count_q <= count_d;
  end

  assign word_count = count_q;
`endif

endmodule
